// File: rtl/gpzda_sentence_tx_pkg.sv
// gpzda_sentence_tx_pkg
//   Shared NMEA definitions for the $GPZDA transmit path: ASCII constants,
//   the sentence header, the sentence length, the checksum index window,
//   the transmitter FSM state type, and a BCD-digit-to-ASCII helper.
//   The receive-side header comparer uses the same header constant.
package gpzda_sentence_tx_pkg;

  localparam logic [7:0] ASC_DOLLAR = 8'h24;
  localparam logic [7:0] ASC_COMMA  = 8'h2C;
  localparam logic [7:0] ASC_DOT    = 8'h2E;
  localparam logic [7:0] ASC_STAR   = 8'h2A;
  localparam logic [7:0] ASC_CR     = 8'h0D;
  localparam logic [7:0] ASC_LF     = 8'h0A;
  localparam logic [7:0] ASC_ZERO   = 8'h30;
  localparam logic [7:0] ASC_UPPER_A = 8'h41;

  // "$GPZDA", first character in the most significant byte.
  localparam logic [47:0] NMEA_HDR = 48'h24_47_50_5A_44_41;

  localparam int SENT_LEN = 38;
  localparam int CS_FIRST = 1;   // first byte folded into the checksum (after '$')
  localparam int CS_LAST  = 32;  // last byte folded in (just before '*')

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // BCD digit to ASCII with no range check: 0xA becomes ':' and so on.
  function automatic logic [7:0] bcd_ascii(input logic [3:0] nibble);
    return ASC_ZERO + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/gpzda_sentence_tx_hex_ascii.sv
// hex_ascii
//   Combinational 4-bit nibble to uppercase ASCII hex character.
//   Ports:
//     nibble  in  4  value 0..15
//     ascii   out 8  '0'..'9' or 'A'..'F'
module hex_ascii
  import gpzda_sentence_tx_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASC_ZERO + {4'h0, nibble};
    end else begin
      ascii = ASC_UPPER_A + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/gpzda_sentence_tx.sv
// gpzda_sentence_tx
//   Builds a fixed 38-byte NMEA sentence
//     $GPZDA,hhmmss.ss,dd,mm,yyyy,zh,zm*CS<CR><LF>
//   from BCD fields latched on start, and streams it one byte per handshake.
//   Ports:
//     clock, restart_n        clock and asynchronous active-low reset
//     start                   request a sentence (ignored unless idle)
//     hour/minute/second/centi, day, month, year, zone_hour, zone_min
//                             BCD fields, sampled on the accepted start edge
//     tx_data, tx_valid, tx_ready
//                             byte stream towards the UART transmitter
//     busy                    sentence in progress
//     done                    one-cycle pulse after the LF is accepted
//     fsm_state               current FSM state, for observation
//
// Stream handshake: a byte transfers on every rising clock edge where
// tx_valid and tx_ready are both high. While tx_valid is high, tx_data is
// held unchanged until that transfer; the following byte is loaded on the
// very edge that completes it. tx_valid never depends combinationally on
// tx_ready.
module gpzda_sentence_tx
  import gpzda_sentence_tx_pkg::*;
#(
  parameter int B = 8,
  parameter int L = 38
) (
  input  logic         clock,
  input  logic         restart_n,
  input  logic         start,
  input  logic [7:0]   hour,
  input  logic [7:0]   minute,
  input  logic [7:0]   second,
  input  logic [7:0]   centi,
  input  logic [7:0]   day,
  input  logic [7:0]   month,
  input  logic [15:0]  year,
  input  logic [7:0]   zone_hour,
  input  logic [7:0]   zone_min,
  output logic [B-1:0] tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         done,
  output state_t       fsm_state
);

  localparam logic [5:0] IDX_LAST = 6'(L - 1);
  localparam logic [5:0] IDX_CS_FIRST = 6'(CS_FIRST);
  localparam logic [5:0] IDX_CS_LAST  = 6'(CS_LAST);

  state_t      state;
  logic [5:0]  idx;
  logic [7:0]  csum;
  logic [7:0]  byte_q;

  logic [7:0]  hour_q, minute_q, second_q, centi_q;
  logic [7:0]  day_q, month_q, zone_hour_q, zone_min_q;
  logic [15:0] year_q;

  logic [5:0]  idx_nxt;
  logic [7:0]  next_byte;
  logic [7:0]  cs_hi_ascii, cs_lo_ascii;
  logic        xfer;

  assign idx_nxt   = idx + 6'd1;
  assign xfer      = tx_valid & tx_ready;
  assign tx_data   = B'(byte_q);
  assign fsm_state = state;

  hex_ascii u_cs_hi (.nibble(csum[7:4]), .ascii(cs_hi_ascii));
  hex_ascii u_cs_lo (.nibble(csum[3:0]), .ascii(cs_lo_ascii));

  // Byte that will be presented after the current one is accepted. The
  // checksum digits are only selected once idx has passed byte 32, by which
  // point csum already holds the complete XOR.
  always_comb begin
    next_byte = 8'h00;
    case (idx_nxt)
      6'd0:  next_byte = NMEA_HDR[47:40];
      6'd1:  next_byte = NMEA_HDR[39:32];
      6'd2:  next_byte = NMEA_HDR[31:24];
      6'd3:  next_byte = NMEA_HDR[23:16];
      6'd4:  next_byte = NMEA_HDR[15:8];
      6'd5:  next_byte = NMEA_HDR[7:0];
      6'd6:  next_byte = ASC_COMMA;
      6'd7:  next_byte = bcd_ascii(hour_q[7:4]);
      6'd8:  next_byte = bcd_ascii(hour_q[3:0]);
      6'd9:  next_byte = bcd_ascii(minute_q[7:4]);
      6'd10: next_byte = bcd_ascii(minute_q[3:0]);
      6'd11: next_byte = bcd_ascii(second_q[7:4]);
      6'd12: next_byte = bcd_ascii(second_q[3:0]);
      6'd13: next_byte = ASC_DOT;
      6'd14: next_byte = bcd_ascii(centi_q[7:4]);
      6'd15: next_byte = bcd_ascii(centi_q[3:0]);
      6'd16: next_byte = ASC_COMMA;
      6'd17: next_byte = bcd_ascii(day_q[7:4]);
      6'd18: next_byte = bcd_ascii(day_q[3:0]);
      6'd19: next_byte = ASC_COMMA;
      6'd20: next_byte = bcd_ascii(month_q[7:4]);
      6'd21: next_byte = bcd_ascii(month_q[3:0]);
      6'd22: next_byte = ASC_COMMA;
      6'd23: next_byte = bcd_ascii(year_q[15:12]);
      6'd24: next_byte = bcd_ascii(year_q[11:8]);
      6'd25: next_byte = bcd_ascii(year_q[7:4]);
      6'd26: next_byte = bcd_ascii(year_q[3:0]);
      6'd27: next_byte = ASC_COMMA;
      6'd28: next_byte = bcd_ascii(zone_hour_q[7:4]);
      6'd29: next_byte = bcd_ascii(zone_hour_q[3:0]);
      6'd30: next_byte = ASC_COMMA;
      6'd31: next_byte = bcd_ascii(zone_min_q[7:4]);
      6'd32: next_byte = bcd_ascii(zone_min_q[3:0]);
      6'd33: next_byte = ASC_STAR;
      6'd34: next_byte = cs_hi_ascii;
      6'd35: next_byte = cs_lo_ascii;
      6'd36: next_byte = ASC_CR;
      6'd37: next_byte = ASC_LF;
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      state       <= S_IDLE;
      idx         <= 6'd0;
      csum        <= 8'h00;
      byte_q      <= 8'h00;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hour_q      <= 8'h00;
      minute_q    <= 8'h00;
      second_q    <= 8'h00;
      centi_q     <= 8'h00;
      day_q       <= 8'h00;
      month_q     <= 8'h00;
      year_q      <= 16'h0000;
      zone_hour_q <= 8'h00;
      zone_min_q  <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            hour_q      <= hour;
            minute_q    <= minute;
            second_q    <= second;
            centi_q     <= centi;
            day_q       <= day;
            month_q     <= month;
            year_q      <= year;
            zone_hour_q <= zone_hour;
            zone_min_q  <= zone_min;
            idx         <= 6'd0;
            csum        <= 8'h00;
            byte_q      <= ASC_DOLLAR;
            tx_valid    <= 1'b1;
            busy        <= 1'b1;
            state       <= S_SEND;
          end
        end
        S_SEND: begin
          if (xfer) begin
            if (idx >= IDX_CS_FIRST && idx <= IDX_CS_LAST) begin
              csum <= csum ^ byte_q;
            end
            if (idx == IDX_LAST) begin
              state    <= S_IDLE;
              idx      <= 6'd0;
              byte_q   <= 8'h00;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              idx    <= idx_nxt;
              byte_q <= next_byte;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpzda_sentence_tx.sv
module tb_gpzda_sentence_tx;
  import gpzda_sentence_tx_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        restart_n = 1'b0;
  always #5 clock = ~clock;

  logic        start = 1'b0;
  logic [7:0]  hour = 8'h00, minute = 8'h00, second = 8'h00, centi = 8'h00;
  logic [7:0]  day = 8'h00, month = 8'h00, zone_hour = 8'h00, zone_min = 8'h00;
  logic [15:0] year = 16'h0000;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;
  state_t      fsm_state;

  gpzda_sentence_tx #(.B(8), .L(38)) dut (
    .clock(clock), .restart_n(restart_n), .start(start),
    .hour(hour), .minute(minute), .second(second), .centi(centi),
    .day(day), .month(month), .year(year),
    .zone_hour(zone_hour), .zone_min(zone_min),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pops = 0;
  int start_cyc = 0;
  int done_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_done = 1'b0;

  always @(negedge clock) begin
    if (restart_n) begin
      if (prev_stall && tx_valid) begin
        checks = checks + 1;
        if (tx_data !== prev_data) begin
          failures = failures + 1;
          $display("FAIL stall_hold: tx_data=%02h required=%02h", tx_data, prev_data);
        end
      end
      if (prev_done && done) begin
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL done_width: done=%0b for two cycles, required one", done);
      end
      if (tx_valid && tx_ready) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL unexpected_byte: tx_data=%02h required=none", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          pops = pops + 1;
          if (tx_data !== e) begin
            failures = failures + 1;
            $display("FAIL byte_%0d: tx_data=%02h required=%02h", pops - 1, tx_data, e);
          end
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_done  = done;
    end else begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end
  end

  // ---------------- golden model ----------------
  function automatic logic [7:0] dig(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  task automatic push_model(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                            input logic [7:0] c, input logic [7:0] d, input logic [7:0] mo,
                            input logic [15:0] y, input logic [7:0] zh, input logic [7:0] zm);
    logic [7:0] b[38];
    logic [7:0] x;
    b[0] = "$"; b[1] = "G"; b[2] = "P"; b[3] = "Z"; b[4] = "D"; b[5] = "A"; b[6] = ",";
    b[7] = dig(h[7:4]);   b[8] = dig(h[3:0]);
    b[9] = dig(mi[7:4]);  b[10] = dig(mi[3:0]);
    b[11] = dig(s[7:4]);  b[12] = dig(s[3:0]);  b[13] = ".";
    b[14] = dig(c[7:4]);  b[15] = dig(c[3:0]);  b[16] = ",";
    b[17] = dig(d[7:4]);  b[18] = dig(d[3:0]);  b[19] = ",";
    b[20] = dig(mo[7:4]); b[21] = dig(mo[3:0]); b[22] = ",";
    b[23] = dig(y[15:12]); b[24] = dig(y[11:8]); b[25] = dig(y[7:4]); b[26] = dig(y[3:0]);
    b[27] = ",";
    b[28] = dig(zh[7:4]); b[29] = dig(zh[3:0]); b[30] = ",";
    b[31] = dig(zm[7:4]); b[32] = dig(zm[3:0]); b[33] = "*";
    x = 8'h00;
    for (int i = 1; i <= 32; i++) x = x ^ b[i];
    b[34] = hexc(x[7:4]); b[35] = hexc(x[3:0]);
    b[36] = 8'h0D; b[37] = 8'h0A;
    for (int i = 0; i < 38; i++) exp_q.push_back(b[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_fields(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                              input logic [7:0] c, input logic [7:0] d, input logic [7:0] mo,
                              input logic [15:0] y, input logic [7:0] zh, input logic [7:0] zm);
    hour = h; minute = mi; second = s; centi = c; day = d; month = mo;
    year = y; zone_hour = zh; zone_min = zm;
  endtask

  // Raises start for one edge; returns #1 after that edge.
  task automatic pulse_start();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic check_first_byte(input string name);
    checks = checks + 1;
    if (tx_valid !== 1'b1 || tx_data !== 8'h24 || busy !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL %s: valid=%0b data=%02h busy=%0b required valid=1 data=24 busy=1",
               name, tx_valid, tx_data, busy);
    end
  endtask

  // Returns at the falling edge of the cycle in which done is high.
  task automatic wait_done(input int max_cycles, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    done_cyc = cyc;
    checks = checks + 1;
    if (!seen) begin
      failures = failures + 1;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic check_queue_empty(input string name);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL %s_missing: %0d bytes left, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_quiet(input string name);
    checks = checks + 1;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL %s: valid=%0b data=%02h busy=%0b done=%0b required all 0",
               name, tx_valid, tx_data, busy, done);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    restart_n = 1'b0;
    repeat (3) @(negedge clock);
    check_quiet("reset_held");
    restart_n = 1'b1;
    repeat (4) @(negedge clock);
    check_quiet("reset_released");
  endtask

  task automatic test_minimal();
    logic [38*8-1:0] lit;
    lit = "$GPZDA,000000.00,01,01,2000,00,00*64\r\n";
    tx_ready = 1'b1;
    drive_fields(8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 16'h2000, 8'h00, 8'h00);
    for (int i = 0; i < 38; i++) exp_q.push_back(lit[(37 - i) * 8 +: 8]);
    pulse_start();
    check_first_byte("minimal_first");
    wait_done(100, "minimal");
    checks = checks + 1;
    if (done_cyc - start_cyc != 38) begin
      failures = failures + 1;
      $display("FAIL minimal_cycles: got=%0d required=38", done_cyc - start_cyc);
    end
    check_queue_empty("minimal");
    @(negedge clock);
    check_quiet("minimal_after");
  endtask

  task automatic test_backpressure();
    bit stop = 1'b0;
    drive_fields(8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 16'h2000, 8'h00, 8'h00);
    push_model(8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 16'h2000, 8'h00, 8'h00);
    tx_ready = 1'b0;
    pulse_start();
    fork
      begin
        int c = 0;
        while (!stop) begin
          if (c >= 4 && c < 16) tx_ready = 1'b0;
          else tx_ready = ($urandom_range(0, 2) != 0);
          c++;
          @(posedge clock); #1;
        end
      end
      begin
        wait_done(3000, "backpressure");
        stop = 1'b1;
      end
    join
    tx_ready = 1'b1;
    check_queue_empty("backpressure");
  endtask

  task automatic test_input_isolation();
    tx_ready = 1'b1;
    drive_fields(8'h12, 8'h34, 8'h56, 8'h78, 8'h31, 8'h12, 16'h2021, 8'h05, 8'h30);
    push_model(8'h12, 8'h34, 8'h56, 8'h78, 8'h31, 8'h12, 16'h2021, 8'h05, 8'h30);
    pulse_start();
    repeat (10) @(posedge clock);
    #1;
    drive_fields(8'($urandom_range(0, 255)), 8'h99, 8'h88, 8'h77, 8'h66, 8'h55,
                 16'h9876, 8'hAB, 8'hCD);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(100, "isolation");
    check_queue_empty("isolation");
    repeat (3) @(negedge clock);
    check_quiet("isolation_no_restart");
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b1;
    drive_fields(8'h23, 8'h59, 8'h59, 8'h99, 8'h28, 8'h02, 16'h1999, 8'h11, 8'h45);
    push_model(8'h23, 8'h59, 8'h59, 8'h99, 8'h28, 8'h02, 16'h1999, 8'h11, 8'h45);
    pulse_start();
    wait_done(100, "b2b_first");
    // Still inside the done cycle: request the next sentence.
    drive_fields(8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 16'h2468, 8'h00, 8'h15);
    push_model(8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 16'h2468, 8'h00, 8'h15);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    checks = checks + 1;
    if (cyc - done_cyc != 1) begin
      failures = failures + 1;
      $display("FAIL b2b_gap: got=%0d required=1", cyc - done_cyc);
    end
    check_first_byte("b2b_second_first");
    start_cyc = cyc;
    wait_done(100, "b2b_second");
    checks = checks + 1;
    if (done_cyc - start_cyc != 38) begin
      failures = failures + 1;
      $display("FAIL b2b_cycles: got=%0d required=38", done_cyc - start_cyc);
    end
    check_queue_empty("b2b");
  endtask

  task automatic test_reset_mid();
    int base;
    bit reached = 1'b0;
    tx_ready = 1'b1;
    drive_fields(8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 16'h2030, 8'h03, 8'h00);
    push_model(8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 16'h2030, 8'h03, 8'h00);
    base = pops;
    pulse_start();
    for (int n = 0; n < 200; n++) begin
      @(negedge clock); #2;
      if (pops - base >= 20) begin
        reached = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    if (!reached) begin
      failures = failures + 1;
      $display("FAIL reset_mid_reach: accepted=%0d required=20", pops - base);
    end
    restart_n = 1'b0;
    #1;
    check_quiet("reset_mid_async");
    exp_q.delete();
    @(negedge clock);
    restart_n = 1'b1;
    drive_fields(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 16'h2007, 8'h08, 8'h09);
    push_model(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 16'h2007, 8'h08, 8'h09);
    pulse_start();
    check_first_byte("reset_mid_restart_first");
    wait_done(100, "reset_mid_restart");
    check_queue_empty("reset_mid_restart");
  endtask

  initial begin
    test_reset();
    test_minimal();
    test_backpressure();
    test_input_isolation();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
